// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler
// Latches floor calls into a pending bitmap and serves them in LOOK order:
// keep sweeping in the current direction, reverse only when nothing lies
// ahead. Each destination is issued to the car controller, and the door is
// held open for DOOR_CYCLES cycles after every stop.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS  = 16,
    parameter int DOOR_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [3:0]            current_floor,
    input  logic                  reached_dest,
    output logic [3:0]            target_floor,
    output logic                  target_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  door_open,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        DISPATCH,
        DOOR
    } state_t;

    localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        door_cnt;
    logic [CNT_W-1:0]        door_cnt_nxt;
    logic [3:0]              target_nxt;
    logic                    valid_nxt;
    logic                    dir_nxt;
    logic                    door_nxt;
    logic [NUM_FLOORS-1:0]   pending_nxt;
    logic [NUM_FLOORS-1:0]   clr;
    logic [NUM_FLOORS-1:0]   latch_mask;

    // Results of the LOOK search over the registered pending bitmap.
    logic                    here_hit;
    logic                    door_call;
    logic                    above_found;
    logic [3:0]              above_floor;
    logic                    below_found;
    logic [3:0]              below_floor;
    logic                    any_pending;

    // One-hot bit for a floor number; loops avoid indexing with a 4-bit bus
    // into a vector that may be narrower than 16 bits.
    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [3:0] floor);
        logic [NUM_FLOORS-1:0] onehot;
        onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (4'(i) == floor) begin
                onehot[i] = 1'b1;
            end
        end
        return onehot;
    endfunction

    assign any_pending = |pending;

    // Locate the nearest pending floor above and below the car, and flag calls at the car's floor.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        here_hit    = 1'b0;
        door_call   = 1'b0;
        above_found = 1'b0;
        above_floor = '0;
        below_found = 1'b0;
        below_floor = '0;
        // Descending scan: the last hit is the lowest floor above the car.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (4'(i) > current_floor)) begin
                above_found = 1'b1;
                above_floor = 4'(i);
            end
        end
        // Ascending scan: the last hit is the highest floor below the car.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (4'(i) < current_floor)) begin
                below_found = 1'b1;
                below_floor = 4'(i);
            end
            if (4'(i) == current_floor) begin
                here_hit  = pending[i];
                door_call = call_btn[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples its pre-edge inputs, independent of block order.
            state <= state_nxt;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_pending) begin
                    state_nxt = SELECT;
                end
            end
            SELECT: begin
                if (!any_pending) begin
                    state_nxt = IDLE;
                end else if (here_hit) begin
                    state_nxt = DOOR;
                end else begin
                    state_nxt = DISPATCH;
                end
            end
            DISPATCH: begin
                if (reached_dest) begin
                    state_nxt = DOOR;
                end
            end
            DOOR: begin
                // A fresh call at this floor keeps the door open instead of leaving.
                if (!door_call && (door_cnt == '0)) begin
                    state_nxt = any_pending ? SELECT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, the request clear and the busy decode.
    always_comb begin
        target_nxt   = target_floor;
        valid_nxt    = target_valid;
        dir_nxt      = dir_up;
        door_nxt     = door_open;
        door_cnt_nxt = door_cnt;
        clr          = '0;
        latch_mask   = '1;
        busy         = (state != IDLE);
        case (state)
            SELECT: begin
                if (any_pending) begin
                    if (here_hit) begin
                        // Already at a requested floor: open the door, no move needed.
                        clr          = floor_bit(current_floor);
                        door_nxt     = 1'b1;
                        door_cnt_nxt = CNT_LOAD;
                    end else begin
                        if (dir_up) begin
                            if (above_found) begin
                                target_nxt = above_floor;
                            end else begin
                                target_nxt = below_floor;
                                dir_nxt    = 1'b0;
                            end
                        end else begin
                            if (below_found) begin
                                target_nxt = below_floor;
                            end else begin
                                target_nxt = above_floor;
                                dir_nxt    = 1'b1;
                            end
                        end
                        valid_nxt = 1'b1;
                    end
                end
            end
            DISPATCH: begin
                if (reached_dest) begin
                    valid_nxt    = 1'b0;
                    clr          = floor_bit(target_floor);
                    door_nxt     = 1'b1;
                    door_cnt_nxt = CNT_LOAD;
                end
            end
            DOOR: begin
                latch_mask = ~floor_bit(current_floor);
                if (door_call) begin
                    door_cnt_nxt = CNT_LOAD;
                end else if (door_cnt == '0) begin
                    door_nxt = 1'b0;
                end else begin
                    door_cnt_nxt = door_cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase
        // The clear is applied last so it beats a same-cycle call on that floor.
        pending_nxt = (pending | (call_btn & latch_mask)) & ~clr;
    end

    // Output and datapath registers; reset drops everything asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= '0;
            target_floor <= '0;
            target_valid <= 1'b0;
            dir_up       <= 1'b1;
            door_open    <= 1'b0;
            door_cnt     <= '0;
        end else begin
            pending      <= pending_nxt;
            target_floor <= target_nxt;
            target_valid <= valid_nxt;
            dir_up       <= dir_nxt;
            door_open    <= door_nxt;
            door_cnt     <= door_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Testbench for elevator_call_scheduler: directed scenarios followed by
// randomized calls and arrivals, every cycle compared against a behavioural
// model that picks destinations by a direction-weighted distance cost.
module tb_elevator_call_scheduler;

    localparam int NF = 16;
    localparam int DC = 4;

    localparam int P_IDLE     = 0;
    localparam int P_SELECT   = 1;
    localparam int P_DISPATCH = 2;
    localparam int P_DOOR     = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NF-1:0] call_btn;
    logic [3:0]    current_floor;
    logic          reached_dest;
    logic [3:0]    target_floor;
    logic          target_valid;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          door_open;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    int            m_phase;
    logic [NF-1:0] m_pend;
    int            m_tgt;
    bit            m_valid;
    bit            m_dir;
    bit            m_door;
    int            m_left;

    elevator_call_scheduler #(
        .NUM_FLOORS  (NF),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .call_btn      (call_btn),
        .current_floor (current_floor),
        .reached_dest  (reached_dest),
        .target_floor  (target_floor),
        .target_valid  (target_valid),
        .pending       (pending),
        .dir_up        (dir_up),
        .door_open     (door_open),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // LOOK choice as a cost: floors ahead cost their distance, floors behind
    // cost a large penalty plus distance, so the nearest floor ahead wins and
    // otherwise the nearest floor behind.
    function automatic int look_pick(input logic [NF-1:0] pend, input int cur, input bit up);
        int best      = -1;
        int best_cost = 1000;
        int cost;
        for (int f = 0; f < NF; f++) begin
            if (pend[f] && f != cur) begin
                if (up) cost = (f > cur) ? (f - cur) : (32 + cur - f);
                else    cost = (f < cur) ? (cur - f) : (32 + f - cur);
                if (cost < best_cost) begin
                    best_cost = cost;
                    best      = f;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_pend  = '0;
        m_tgt   = 0;
        m_valid = 1'b0;
        m_dir   = 1'b1;
        m_door  = 1'b0;
        m_left  = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_update();
        logic [NF-1:0] calls;
        logic [NF-1:0] old_pend;
        int            clear_floor;
        int            cur;
        int            pick;
        calls       = call_btn;
        old_pend    = m_pend;
        clear_floor = -1;
        cur         = int'(current_floor);
        case (m_phase)
            P_IDLE: begin
                if (old_pend != 0) m_phase = P_SELECT;
            end
            P_SELECT: begin
                if (old_pend == 0) begin
                    m_phase = P_IDLE;
                end else if (old_pend[cur]) begin
                    clear_floor = cur;
                    m_door      = 1'b1;
                    m_left      = DC;
                    m_phase     = P_DOOR;
                end else begin
                    pick    = look_pick(old_pend, cur, m_dir);
                    m_dir   = (pick > cur);
                    m_tgt   = pick;
                    m_valid = 1'b1;
                    m_phase = P_DISPATCH;
                end
            end
            P_DISPATCH: begin
                if (reached_dest) begin
                    m_valid     = 1'b0;
                    clear_floor = m_tgt;
                    m_door      = 1'b1;
                    m_left      = DC;
                    m_phase     = P_DOOR;
                end
            end
            default: begin
                calls[cur] = 1'b0;
                if (call_btn[cur]) begin
                    m_left = DC;
                end else if (m_left == 1) begin
                    m_door  = 1'b0;
                    m_phase = (old_pend != 0) ? P_SELECT : P_IDLE;
                end else begin
                    m_left--;
                end
            end
        endcase
        m_pend = old_pend | calls;
        if (clear_floor >= 0) m_pend[clear_floor] = 1'b0;
    endtask

    task automatic compare_all();
        check("target_floor", 32'(target_floor), 32'(m_tgt));
        check("target_valid", 32'(target_valid), 32'(m_valid));
        check("pending",      32'(pending),      32'(m_pend));
        check("dir_up",       32'(dir_up),       32'(m_dir));
        check("door_open",    32'(door_open),    32'(m_door));
        check("busy",         32'(busy),         32'(m_phase != P_IDLE));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!target_valid && n < 50) begin
            step();
            n++;
        end
        check(tag, 32'(target_valid), 32'd1);
    endtask

    task automatic arrive(input int floor);
        int n = 0;
        current_floor = 4'(floor);
        reached_dest  = 1'b1;
        step();
        reached_dest  = 1'b0;
        while (door_open && n < 50) begin
            step();
            n++;
        end
        check("arrive_door_closed", 32'(door_open), 32'd0);
    endtask

    initial begin
        int  cnt;
        int  n;
        bit  saw_valid;
        int  r;

        reset_n       = 1'b0;
        call_btn      = '0;
        current_floor = 4'd0;
        reached_dest  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_dir_up", 32'(dir_up), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Single call upward with 2-cycle dispatch latency and a 4-cycle door.
        current_floor = 4'd2;
        call_btn      = 16'h0080;
        step();
        call_btn = '0;
        check("t1_pending7_set", 32'(pending[7]), 32'd1);
        step();
        check("t1_valid_not_yet", 32'(target_valid), 32'd0);
        step();
        check("t1_valid", 32'(target_valid), 32'd1);
        check("t1_target", 32'(target_floor), 32'd7);
        step();
        step();
        current_floor = 4'd7;
        reached_dest  = 1'b1;
        step();
        reached_dest = 1'b0;
        check("t1_pending7_clear", 32'(pending[7]), 32'd0);
        check("t1_door_rise", 32'(door_open), 32'd1);
        check("t1_valid_drop", 32'(target_valid), 32'd0);
        cnt = 1;
        n   = 0;
        while (door_open && n < 20) begin
            step();
            if (door_open) cnt++;
            n++;
        end
        check("t1_door_len", 32'(cnt), 32'd4);
        check("t1_idle", 32'(busy), 32'd0);

        // LOOK order from floor 5 going up with calls at 3, 8 and 12.
        current_floor = 4'd5;
        call_btn      = 16'h1108;
        step();
        call_btn = '0;
        wait_valid("t2_first_timeout");
        check("t2_first", 32'(target_floor), 32'd8);
        arrive(8);
        wait_valid("t2_second_timeout");
        check("t2_second", 32'(target_floor), 32'd12);
        check("t2_second_dir", 32'(dir_up), 32'd1);
        arrive(12);
        wait_valid("t2_third_timeout");
        check("t2_third", 32'(target_floor), 32'd3);
        check("t2_third_dir", 32'(dir_up), 32'd0);
        arrive(3);

        // Call at the floor the car is idling on, then a re-press during DOOR.
        current_floor = 4'd4;
        saw_valid     = 1'b0;
        call_btn      = 16'h0010;
        step();
        call_btn = '0;
        n = 0;
        while (!door_open && n < 10) begin
            step();
            if (target_valid) saw_valid = 1'b1;
            n++;
        end
        check("t3_door_rise", 32'(door_open), 32'd1);
        cnt = 1;
        repeat (2) begin
            step();
            if (door_open) cnt++;
        end
        call_btn = 16'h0010;
        step();
        call_btn = '0;
        if (door_open) cnt++;
        check("t3_pending4_not_latched", 32'(pending[4]), 32'd0);
        n = 0;
        while (door_open && n < 20) begin
            step();
            if (target_valid) saw_valid = 1'b1;
            if (door_open) cnt++;
            n++;
        end
        check("t3_door_len_reloaded", 32'(cnt), 32'd7);
        check("t3_no_dispatch", 32'(saw_valid), 32'd0);

        // No preemption by a nearer call; spurious arrival while idle.
        current_floor = 4'd2;
        call_btn      = 16'h0400;
        step();
        call_btn = '0;
        wait_valid("t4_timeout");
        check("t4_target", 32'(target_floor), 32'd10);
        call_btn = 16'h0008;
        step();
        call_btn = '0;
        repeat (3) step();
        check("t4_target_held", 32'(target_floor), 32'd10);
        check("t4_valid_held", 32'(target_valid), 32'd1);
        check("t4_pending3", 32'(pending[3]), 32'd1);
        arrive(10);
        wait_valid("t4_next_timeout");
        check("t4_next", 32'(target_floor), 32'd3);
        arrive(3);
        step();
        reached_dest = 1'b1;
        step();
        reached_dest = 1'b0;
        check("t4_spurious_busy", 32'(busy), 32'd0);
        check("t4_spurious_door", 32'(door_open), 32'd0);

        // Clear beats a same-cycle call on the target floor.
        current_floor = 4'd3;
        call_btn      = 16'h0040;
        step();
        call_btn = '0;
        wait_valid("t5_timeout");
        check("t5_target", 32'(target_floor), 32'd6);
        current_floor = 4'd6;
        reached_dest  = 1'b1;
        call_btn      = 16'h0040;
        step();
        reached_dest = 1'b0;
        call_btn     = '0;
        check("t5_clear_wins", 32'(pending[6]), 32'd0);
        n = 0;
        while (door_open && n < 20) begin
            step();
            n++;
        end

        // Reset in the middle of a dispatch with calls 1 and 9 pending.
        call_btn = 16'h0202;
        step();
        call_btn = '0;
        wait_valid("t6_timeout");
        check("t6_target", 32'(target_floor), 32'd9);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("t6_async_valid", 32'(target_valid), 32'd0);
        check("t6_async_pending", 32'(pending), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) step();
        check("t6_no_dispatch", 32'(target_valid), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);

        // Randomized calls, arrivals and spurious arrivals.
        for (int c = 0; c < 2000; c++) begin
            call_btn     = '0;
            reached_dest = 1'b0;
            r = $urandom_range(0, 7);
            if (r == 0) call_btn[$urandom_range(0, NF - 1)] = 1'b1;
            if (r == 1) call_btn[current_floor] = 1'b1;
            if (r == 2) begin
                call_btn[$urandom_range(0, NF - 1)] = 1'b1;
                call_btn[$urandom_range(0, NF - 1)] = 1'b1;
            end
            if (m_valid && $urandom_range(0, 3) == 0) begin
                current_floor = 4'(m_tgt);
                reached_dest  = 1'b1;
            end else if (!m_valid && $urandom_range(0, 15) == 0) begin
                reached_dest = 1'b1;
            end
            step();
        end

        // Drain all remaining requests.
        call_btn     = '0;
        reached_dest = 1'b0;
        n = 0;
        while ((m_phase != P_IDLE || m_pend != 0) && n < 500) begin
            reached_dest = 1'b0;
            if (m_valid) begin
                current_floor = 4'(m_tgt);
                reached_dest  = 1'b1;
            end
            step();
            n++;
        end
        reached_dest = 1'b0;
        step();
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_pending", 32'(pending), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Request-side companion to the elevator car controller. Latches floor-call buttons into a pending bitmap, chooses the next destination with a LOOK sweep (continue in the current direction, reverse only when nothing lies ahead), and issues it as `target_floor`/`target_valid`. After the controller pulses `reached_dest`, it holds the door open for a fixed time, then serves the next request.

## Interface
- `NUM_FLOORS`, 16: number of served floors, 2..16. Floor indices are 0..NUM_FLOORS-1 on a fixed 4-bit bus.
- `DOOR_CYCLES`, 8: door-open duration in clk cycles, ≥1.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `call_btn` in NUM_FLOORS: call requests, one bit per floor, sampled every posedge (pulse or level).
- `current_floor` in 4: car position from the car controller. Always < NUM_FLOORS.
- `reached_dest` in 1: arrival pulse from the car controller.
- `target_floor` out 4: destination issued to the controller.
- `target_valid` out 1: high while a destination is outstanding.
- `pending` out NUM_FLOORS: latched, unserved requests (button lamps).
- `dir_up` out 1: sweep direction (1 = up).
- `door_open` out 1: door-open indication.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Reset values:** FSM = IDLE; `pending` = 0; `target_floor` = 0; `target_valid` = 0; `dir_up` = 1; `door_open` = 0; `busy` = 0.
- **Request latch:** every cycle, `pending <= (pending | call_btn) & ~clr`.
  - `clr` is the one-hot bit of the floor being served this cycle.
  - When a set and a clear hit the same bit in the same cycle, the clear wins.
- **Call at the floor being served:** a `call_btn` bit equal to `current_floor` while in DOOR is not latched. It reloads the door counter instead.
- **FSM states:** IDLE, SELECT, DISPATCH, DOOR.
- **IDLE:**
  - `pending` ≠ 0 → SELECT.
- **SELECT** (one cycle; choice is combinational from registered `pending`, `current_floor`, `dir_up`):
  - `pending[current_floor]` set → clear it, `door_open` = 1, load counter, → DOOR. No dispatch is issued, because the controller cannot complete a move to the floor it is already on.
  - Else, if `dir_up` = 1:
    - Pick the lowest pending floor above `current_floor`.
    - If there is none, pick the highest pending floor below it and set `dir_up` = 0.
  - Else (`dir_up` = 0):
    - Pick the highest pending floor below `current_floor`.
    - If there is none, pick the lowest pending floor above it and set `dir_up` = 1.
  - After picking: register `target_floor`, `target_valid` = 1, → DISPATCH.
  - `pending` = 0 (cannot normally occur) → IDLE.
- **DISPATCH:**
  - `target_floor` and `target_valid` are held stable. No preemption: new calls, including nearer ones, do not change the target.
  - On `reached_dest` = 1: `target_valid` = 0, clear `pending[target_floor]`, `door_open` = 1, load counter = DOOR_CYCLES-1, → DOOR.
- **DOOR:**
  - Counter decrements each cycle.
  - At 0: `door_open` = 0, then → SELECT if `pending` ≠ 0, else → IDLE.
- **Ignored inputs:** `reached_dest` outside DISPATCH.
- **Reset mid-operation:** all state returns to reset values immediately. Pending requests are discarded, and `target_valid` drops asynchronously.

## Timing
- A call sampled at edge N:
  - `pending` bit visible after edge N.
  - IDLE→SELECT at edge N+1.
  - `target_valid` = 1 after edge N+2 (2-cycle dispatch latency from the sampling edge).
- `reached_dest` sampled at edge M:
  - `target_valid` = 0 and `door_open` = 1 after edge M.
  - `door_open` stays high for exactly DOOR_CYCLES cycles, falling after edge M+DOOR_CYCLES.
  - Next `target_valid` comes DOOR_CYCLES+1 edges after M when requests remain.
- Current-floor service from SELECT: `door_open` rises one cycle after SELECT is entered and stays high for DOOR_CYCLES cycles.
- `dir_up` updates on the same edge that registers `target_floor`.
- All outputs are registered except `busy`, which is decoded from the state register.

## Test plan
- **Single call upward:** DOOR_CYCLES = 4, `current_floor` = 2, pulse `call_btn[7]` → `target_floor` = 7 with `target_valid` 2 cycles later. Pulse `reached_dest` → `pending[7]` = 0, `door_open` high for exactly 4 cycles, return to IDLE.
- **LOOK order:** `current_floor` = 5, `dir_up` = 1, pending {3, 8, 12} → dispatches 8, 12, then 3. `dir_up` falls at the edge issuing 3. Drive `current_floor` to match on each arrival.
- **Call at the current floor:** idle at 4, pulse `call_btn[4]` → `target_valid` never rises, `door_open` high for 4 cycles. Re-pulse `call_btn[4]` during DOOR → counter reloads, `pending[4]` stays 0.
- **No preemption / spurious arrival:** while dispatching 10 from 2, call 3 → target stays 10. `reached_dest` pulsed in IDLE → no state change.
- **Clear wins:** `call_btn[target]` asserted in the same cycle as `reached_dest` → `pending[target]` = 0 afterwards.
- **Reset mid-operation:** assert `reset_n` low mid-DISPATCH with pending {1, 9} → all outputs at reset values within the same cycle. After release, no dispatch occurs without new calls.
